switch_send_queue: RTL and testbench

- Per-core outbound buffer between a VecCore send unit and the Switch send port.
- Accepts destination-tagged vectors from the core and holds them in a FIFO.
- Presents the head entry to the Switch and retires it only when the Switch grants send_ok.
- Decouples core issue from switch arbitration stalls; one instance per core, indexed alongside the core array.

---
 rtl/switch_send_queue.sv | 153 +++++++++++++++
 tb/tb_switch_send_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_send_queue.sv
// switch_send_queue: per-core outbound FIFO between a VecCore send unit and
// the Switch send port. Destination-tagged vectors are queued on enqueue and
// the head is presented to the Switch until it grants send_ok.
//
// Vector lanes are carried as raw 32-bit IEEE-754 single-precision patterns
// (lane i occupies bits [32*i +: 32]); 0.0 is all-zero bits.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   enq_valid/enq_ready   core-side handshake; enq_core_idx/enq_data payload
//   flush                 synchronous discard of every queued entry
//   send_ready/send_ok    switch-side handshake; send_core_idx/send_data head
//   count, idle           occupancy (0..DEPTH) and count==0
//   proto_err             sticky: send_ok observed while send_ready low
//   stall_cycles, sent_count  (only with SWITCH_SEND_QUEUE_STATS_EN) saturating
//                         counters of stalled head cycles and retired entries
//
// Optional feature macro: SWITCH_SEND_QUEUE_STATS_EN
module switch_send_queue #(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned CORE_SIZE      = 2,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned CORE_ADDR_SIZE = $clog2(CORE_SIZE),
  parameter int unsigned PTR_SIZE       = $clog2(DEPTH)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enq_valid,
  input  logic [CORE_ADDR_SIZE-1:0] enq_core_idx,
  input  logic [WIDTH*32-1:0]       enq_data,
  output logic                      enq_ready,
  input  logic                      flush,
  output logic                      send_ready,
  output logic [CORE_ADDR_SIZE-1:0] send_core_idx,
  output logic [WIDTH*32-1:0]       send_data,
  input  logic                      send_ok,
  output logic [PTR_SIZE:0]         count,
  output logic                      idle,
`ifdef SWITCH_SEND_QUEUE_STATS_EN
  output logic [31:0]               stall_cycles,
  output logic [31:0]               sent_count,
`endif
  output logic                      proto_err
);

  localparam int unsigned DATA_W = WIDTH * 32;
  localparam int unsigned CNT_W  = PTR_SIZE + 1;

  logic [DATA_W-1:0]         data_q [DEPTH];
  logic [DATA_W-1:0]         data_d [DEPTH];
  logic [CORE_ADDR_SIZE-1:0] idx_q  [DEPTH];
  logic [CORE_ADDR_SIZE-1:0] idx_d  [DEPTH];
  logic [PTR_SIZE-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_SIZE-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      proto_err_q, proto_err_d;
  logic                      push, pop;

  // Handshakes depend only on registered occupancy, so a pop cannot free a
  // slot for an enqueue in the same cycle.
  assign enq_ready     = (count_q != CNT_W'(DEPTH));
  assign send_ready    = (count_q != '0);
  assign idle          = (count_q == '0);
  assign count         = count_q;
  assign send_data     = data_q[rd_ptr_q];
  assign send_core_idx = idx_q[rd_ptr_q];
  assign proto_err     = proto_err_q;

  assign push = enq_valid && enq_ready;
  assign pop  = send_ready && send_ok;

  // Next-state for storage, pointers, occupancy and the protocol flag.
  always_comb begin
    data_d      = data_q;
    idx_d       = idx_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    proto_err_d = proto_err_q | (send_ok & ~send_ready);
    if (flush) begin
      // Flush wins over any concurrent push or pop.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = enq_data;
        idx_d[wr_ptr_q]  = enq_core_idx;
        wr_ptr_d         = wr_ptr_q + PTR_SIZE'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_SIZE'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared on reset so the idle head reads 0.0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      data_q      <= data_d;
      idx_q       <= idx_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

`ifdef SWITCH_SEND_QUEUE_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] sent_count_q, sent_count_d;

  assign stall_cycles = stall_cycles_q;
  assign sent_count   = sent_count_q;

  // Saturating statistics; a pop cancelled by flush is not counted as sent.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    sent_count_d   = sent_count_q;
    if (send_ready && !send_ok && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (pop && !flush && (sent_count_q != '1)) begin
      sent_count_d = sent_count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles_q <= '0;
      sent_count_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      sent_count_q   <= sent_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_switch_send_queue.sv
// Directed self-checking bench for switch_send_queue (WIDTH=16, CORE_SIZE=2,
// DEPTH=4). Inputs change #1 after a rising edge; outputs are checked there.
module tb_switch_send_queue;

  localparam int unsigned DW = 16 * 32;

  logic          clock;
  logic          reset;
  logic          enq_valid;
  logic [0:0]    enq_core_idx;
  logic [DW-1:0] enq_data;
  logic          enq_ready;
  logic          flush;
  logic          send_ready;
  logic [0:0]    send_core_idx;
  logic [DW-1:0] send_data;
  logic          send_ok;
  logic [2:0]    count;
  logic          idle;
  logic          proto_err;
`ifdef SWITCH_SEND_QUEUE_STATS_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   sent_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // IEEE-754 single-precision encodings of 0.0 .. 15.0.
  localparam logic [31:0] FLT [16] = '{
    32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
    32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000,
    32'h4100_0000, 32'h4110_0000, 32'h4120_0000, 32'h4130_0000,
    32'h4140_0000, 32'h4150_0000, 32'h4160_0000, 32'h4170_0000
  };

  switch_send_queue dut (
    .clock         (clock),
    .reset         (reset),
    .enq_valid     (enq_valid),
    .enq_core_idx  (enq_core_idx),
    .enq_data      (enq_data),
    .enq_ready     (enq_ready),
    .flush         (flush),
    .send_ready    (send_ready),
    .send_core_idx (send_core_idx),
    .send_data     (send_data),
    .send_ok       (send_ok),
    .count         (count),
    .idle          (idle),
`ifdef SWITCH_SEND_QUEUE_STATS_EN
    .stall_cycles  (stall_cycles),
    .sent_count    (sent_count),
`endif
    .proto_err     (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Distinct tagged vector: lane i = {tag, i}.
  function automatic logic [DW-1:0] vec(input int tag);
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = {16'(tag), 16'(i)};
    return v;
  endfunction

  function automatic logic [DW-1:0] flt_ramp();
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = FLT[i];
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic enq_one(input int tag, input logic idx);
    enq_valid = 1'b1; enq_data = vec(tag); enq_core_idx = idx;
    tick();
    enq_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enq_valid = 1'b0; enq_core_idx = '0; enq_data = '0;
    flush = 1'b0; send_ok = 1'b0;
    tick(); tick();
    if (idle !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b expected 1", idle); end n_tests++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end n_tests++;
    if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready: got %b expected 1", enq_ready); end n_tests++;
    if (send_ready !== 1'b0) begin n_fail++; $display("FAIL reset_send_ready: got %b expected 0", send_ready); end n_tests++;
    if (send_data !== '0) begin n_fail++; $display("FAIL reset_send_data: got %h expected 0", send_data); end n_tests++;
    if (send_core_idx !== 1'b0) begin n_fail++; $display("FAIL reset_core_idx: got %b expected 0", send_core_idx); end n_tests++;
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b expected 0", proto_err); end n_tests++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_pass();
    logic [DW-1:0] exp_v;
    exp_v = flt_ramp();
    enq_valid = 1'b1; enq_core_idx = 1'b1; enq_data = exp_v;
    tick();
    enq_valid = 1'b0; enq_data = '0;
    if (send_ready !== 1'b1) begin n_fail++; $display("FAIL single_send_ready: got %b expected 1", send_ready); end n_tests++;
    if (send_data !== exp_v) begin n_fail++; $display("FAIL single_data: got %h expected %h", send_data, exp_v); end n_tests++;
    if (send_core_idx !== 1'b1) begin n_fail++; $display("FAIL single_idx: got %b expected 1", send_core_idx); end n_tests++;
    if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", count); end n_tests++;
    send_ok = 1'b1;
    tick();
    send_ok = 1'b0;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b expected 1", idle); end n_tests++;
    if (send_ready !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b expected 0", send_ready); end n_tests++;
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL single_proto_err: got %b expected 0", proto_err); end n_tests++;
  endtask

  task automatic test_fill_backpressure();
    for (int k = 1; k <= 5; k++) begin
      if (enq_ready !== (k <= 4)) begin n_fail++; $display("FAIL fill_enq_ready_%0d: got %b expected %b", k, enq_ready, (k <= 4)); end n_tests++;
      enq_one(k, 1'(k % 2));
    end
    if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end n_tests++;
    if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %b expected 0", enq_ready); end n_tests++;
    send_ok = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      if (send_data !== vec(k)) begin n_fail++; $display("FAIL drain_data_%0d: got %h expected %h", k, send_data, vec(k)); end n_tests++;
      if (send_core_idx !== 1'(k % 2)) begin n_fail++; $display("FAIL drain_idx_%0d: got %b expected %b", k, send_core_idx, 1'(k % 2)); end n_tests++;
      tick();
    end
    send_ok = 1'b0;
    if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d expected 0", count); end n_tests++;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL drain_idle: got %b expected 1", idle); end n_tests++;
  endtask

  task automatic test_concurrent();
    enq_one(11, 1'b0);
    enq_one(12, 1'b1);
    // count=2: push and pop together.
    enq_valid = 1'b1; enq_data = vec(13); enq_core_idx = 1'b0; send_ok = 1'b1;
    if (send_data !== vec(11)) begin n_fail++; $display("FAIL conc_head_before: got %h expected %h", send_data, vec(11)); end n_tests++;
    tick();
    enq_valid = 1'b0; send_ok = 1'b0;
    if (count !== 3'd2) begin n_fail++; $display("FAIL conc_count: got %0d expected 2", count); end n_tests++;
    if (send_data !== vec(12)) begin n_fail++; $display("FAIL conc_head_after: got %h expected %h", send_data, vec(12)); end n_tests++;
    enq_one(14, 1'b0);
    enq_one(15, 1'b1);
    // count=4: only the pop is taken.
    enq_valid = 1'b1; enq_data = vec(16); send_ok = 1'b1;
    if (enq_ready !== 1'b0) begin n_fail++; $display("FAIL conc_full_ready: got %b expected 0", enq_ready); end n_tests++;
    tick();
    enq_valid = 1'b0;
    if (count !== 3'd3) begin n_fail++; $display("FAIL conc_full_count: got %0d expected 3", count); end n_tests++;
    for (int k = 13; k <= 15; k++) begin
      if (send_data !== vec(k)) begin n_fail++; $display("FAIL conc_order_%0d: got %h expected %h", k, send_data, vec(k)); end n_tests++;
      tick();
    end
    send_ok = 1'b0;
    if (count !== 3'd0) begin n_fail++; $display("FAIL conc_end_count: got %0d expected 0", count); end n_tests++;
  endtask

  task automatic test_flush();
    enq_one(21, 1'b0);
    enq_one(22, 1'b1);
    enq_one(23, 1'b0);
    if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count); end n_tests++;
    flush = 1'b1; enq_valid = 1'b1; enq_data = vec(24);
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end n_tests++;
    if (send_ready !== 1'b0) begin n_fail++; $display("FAIL flush_send_ready: got %b expected 0", send_ready); end n_tests++;
    enq_one(25, 1'b1);
    if (count !== 3'd1) begin n_fail++; $display("FAIL flush_reenq_count: got %0d expected 1", count); end n_tests++;
    if (send_data !== vec(25)) begin n_fail++; $display("FAIL flush_dropped: got %h expected %h", send_data, vec(25)); end n_tests++;
    send_ok = 1'b1;
    tick();
    send_ok = 1'b0;
    if (idle !== 1'b1) begin n_fail++; $display("FAIL flush_end_idle: got %b expected 1", idle); end n_tests++;
  endtask

  task automatic test_reset_mid();
    enq_one(31, 1'b1);
    enq_one(32, 1'b0);
    reset = 1'b1; send_ok = 1'b1;
    tick();
    reset = 1'b0; send_ok = 1'b0;
    if (count !== 3'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 0", count); end n_tests++;
    if (send_data !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", send_data); end n_tests++;
    if (proto_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_proto_err: got %b expected 0", proto_err); end n_tests++;
  endtask

  task automatic test_proto_err();
    send_ok = 1'b1;
    tick();
    send_ok = 1'b0;
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_set: got %b expected 1", proto_err); end n_tests++;
    if (count !== 3'd0) begin n_fail++; $display("FAIL proto_count: got %0d expected 0", count); end n_tests++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end n_tests++;
    if (enq_ready !== 1'b1) begin n_fail++; $display("FAIL proto_enq_ready: got %b expected 1", enq_ready); end n_tests++;
  endtask

`ifdef SWITCH_SEND_QUEUE_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (stall_cycles !== 32'd0) begin n_fail++; $display("FAIL stats_rst_stall: got %0d expected 0", stall_cycles); end n_tests++;
    enq_one(41, 1'b0);
    enq_one(42, 1'b1);
    tick();
    tick();
    send_ok = 1'b1;
    tick();
    tick();
    send_ok = 1'b0;
    if (stall_cycles !== 32'd3) begin n_fail++; $display("FAIL stats_stall: got %0d expected 3", stall_cycles); end n_tests++;
    if (sent_count !== 32'd2) begin n_fail++; $display("FAIL stats_sent: got %0d expected 2", sent_count); end n_tests++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_pass();
    test_fill_backpressure();
    test_concurrent();
    test_flush();
    test_reset_mid();
    test_proto_err();
`ifdef SWITCH_SEND_QUEUE_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
